// File: rtl/stopwatch_core_if.sv
// stopwatch_core_if: divider tick input, debounced keys and display/status outputs of the stopwatch core
interface stopwatch_core_if;
    logic        clk_100hz;
    logic        key_ss;
    logic        key_lap;
    logic        key_clr;
    logic [23:0] disp_bcd;
    logic        running;
    logic        lap_hold;
    logic        ovf;
    modport master (
        output clk_100hz, key_ss, key_lap, key_clr,
        input  disp_bcd, running, lap_hold, ovf
    );
    modport slave (
        input  clk_100hz, key_ss, key_lap, key_clr,
        output disp_bcd, running, lap_hold, ovf
    );
endinterface

// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS.CC BCD stopwatch with start/stop, lap freeze and clear, ticked by a sampled 100 Hz wave
module stopwatch_core #(
    parameter int unsigned MIN_MAX = 59
) (
    input logic              clk_50mhz,
    input logic              rst,
    stopwatch_core_if.slave  sw_if
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
    localparam logic [3:0] MH = 4'(MIN_MAX / 10);
    localparam logic [3:0] ML = 4'(MIN_MAX % 10);
    state_t      state_q, state_d;
    logic        d1_q, d2_q;
    logic [2:0]  key_q;
    logic [23:0] cnt_q, cnt_d, snap_q, snap_d, disp_q;
    logic        ovf_q;
    logic        tick, ss_p, lap_p, clr_p, zero, at_max, wrap;
    logic [5:0]  c;
    assign tick = d1_q & ~d2_q;
    assign {clr_p, lap_p, ss_p} = {sw_if.key_clr, sw_if.key_lap, sw_if.key_ss} & ~key_q;
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        zero    = 1'b0;
        unique case (state_q)
            IDLE:  if (clr_p) zero = 1'b1;
                   else if (ss_p) state_d = RUN;
            RUN:   if (ss_p) state_d = PAUSE;
                   else if (lap_p) begin
                       state_d = LAP;
                       snap_d  = cnt_q;
                   end
            LAP:   if (ss_p) state_d = PAUSE;
                   else if (lap_p) state_d = RUN;
            PAUSE: if (clr_p) begin
                       state_d = IDLE;
                       zero    = 1'b1;
                   end else if (ss_p) state_d = RUN;
        endcase
        if (zero) snap_d = '0;
    end
    // c[i] is the carry into digit i; the whole chain ripples within the tick cycle
    assign c[0]   = tick & (state_q == RUN | state_q == LAP);
    assign c[1]   = c[0] & (cnt_q[3:0] == 4'd9);
    assign c[2]   = c[1] & (cnt_q[7:4] == 4'd9);
    assign c[3]   = c[2] & (cnt_q[11:8] == 4'd9);
    assign c[4]   = c[3] & (cnt_q[15:12] == 4'd5);
    assign at_max = cnt_q[23:16] == {MH, ML};
    assign wrap   = c[4] & at_max;
    assign c[5]   = c[4] & ~at_max & (cnt_q[19:16] == 4'd9);
    assign cnt_d  = zero ? '0 : {
        wrap          ? 4'd0 : cnt_q[23:20] + 4'(c[5]),
        (c[5] | wrap) ? 4'd0 : cnt_q[19:16] + 4'(c[4]),
        c[4]          ? 4'd0 : cnt_q[15:12] + 4'(c[3]),
        c[3]          ? 4'd0 : cnt_q[11:8]  + 4'(c[2]),
        c[2]          ? 4'd0 : cnt_q[7:4]   + 4'(c[1]),
        c[1]          ? 4'd0 : cnt_q[3:0]   + 4'(c[0])
    };
    always_ff @(posedge clk_50mhz) begin
        if (!rst) begin
            state_q <= IDLE;
            d1_q    <= 1'b0;
            d2_q    <= 1'b0;
            key_q   <= '0;
            cnt_q   <= '0;
            snap_q  <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d1_q    <= sw_if.clk_100hz;
            d2_q    <= d1_q;
            key_q   <= {sw_if.key_clr, sw_if.key_lap, sw_if.key_ss};
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            disp_q  <= (state_q == LAP) ? snap_q : cnt_q;
            ovf_q   <= wrap;
        end
    end
    assign sw_if.disp_bcd = disp_q;
    assign sw_if.running  = state_q == RUN | state_q == LAP;
    assign sw_if.lap_hold = state_q == LAP;
    assign sw_if.ovf      = ovf_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: random and directed stimulus against a centisecond-count reference model
module tb_stopwatch_core;
    localparam int MIN_MAX = 1;
    localparam int MODC    = (MIN_MAX + 1) * 6000;
    typedef enum int {S_IDLE, S_RUN, S_PAUSE, S_LAP} st_t;
    logic clk_50mhz = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    st_t  m_state = S_IDLE;
    int   m_cs = 0, m_snap = 0, m_disp = 0;
    bit   m_ovf, h1, h2, kp_ss, kp_lap, kp_clr;
    bit   hz_auto = 1'b0;
    int   hz_left = 1;
    always #5 clk_50mhz = ~clk_50mhz;
    stopwatch_core_if sw_if ();
    stopwatch_core #(.MIN_MAX(MIN_MAX)) dut (
        .clk_50mhz(clk_50mhz),
        .rst(rst),
        .sw_if(sw_if)
    );
    function automatic logic [23:0] bcd(int cs);
        int mm = cs / 6000;
        int ss = (cs / 100) % 60;
        int cc = cs % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // Reference: time is an integer count of centiseconds modulo the full span
    task automatic model_edge();
        bit tick, p_ss, p_lap, p_clr, counted;
        int nxt;
        st_t ns;
        if (!rst) begin
            m_state = S_IDLE; m_cs = 0; m_snap = 0; m_disp = 0; m_ovf = 0;
            h1 = 0; h2 = 0; kp_ss = 0; kp_lap = 0; kp_clr = 0;
            return;
        end
        tick = h1 && !h2;
        h2 = h1;
        h1 = sw_if.clk_100hz;
        p_ss  = sw_if.key_ss && !kp_ss;
        p_lap = sw_if.key_lap && !kp_lap;
        p_clr = sw_if.key_clr && !kp_clr;
        kp_ss = sw_if.key_ss; kp_lap = sw_if.key_lap; kp_clr = sw_if.key_clr;
        m_disp  = (m_state == S_LAP) ? m_snap : m_cs;
        counted = tick && (m_state == S_RUN || m_state == S_LAP);
        m_ovf   = counted && m_cs == MODC - 1;
        nxt = counted ? (m_cs + 1) % MODC : m_cs;
        ns = m_state;
        case (m_state)
            S_IDLE:  if (p_clr) begin nxt = 0; m_snap = 0; end
                     else if (p_ss) ns = S_RUN;
            S_RUN:   if (p_ss) ns = S_PAUSE;
                     else if (p_lap) begin ns = S_LAP; m_snap = m_cs; end
            S_LAP:   if (p_ss) ns = S_PAUSE;
                     else if (p_lap) ns = S_RUN;
            S_PAUSE: if (p_clr) begin ns = S_IDLE; nxt = 0; m_snap = 0; end
                     else if (p_ss) ns = S_RUN;
            default: ns = S_IDLE;
        endcase
        m_state = ns;
        m_cs = nxt;
    endtask
    task automatic cycle();
        @(posedge clk_50mhz);
        model_edge();
        @(negedge clk_50mhz);
        check("disp", sw_if.disp_bcd, bcd(m_disp));
        check("flags", {sw_if.running, sw_if.lap_hold, sw_if.ovf},
              {m_state == S_RUN || m_state == S_LAP, m_state == S_LAP, m_ovf});
        if (hz_auto) begin
            hz_left--;
            if (hz_left <= 0) begin
                sw_if.clk_100hz = ~sw_if.clk_100hz;
                hz_left = $urandom_range(1, 2);
            end
        end
    endtask
    task automatic tick_n(int n);
        repeat (n) begin
            sw_if.clk_100hz = 1'b1;
            repeat (2) cycle();
            sw_if.clk_100hz = 1'b0;
            repeat (2) cycle();
        end
    endtask
    task automatic press(logic [2:0] m, int hold);
        {sw_if.key_clr, sw_if.key_lap, sw_if.key_ss} = m;
        repeat (hold) cycle();
        {sw_if.key_clr, sw_if.key_lap, sw_if.key_ss} = 3'b000;
        cycle();
    endtask
    task automatic run_to(int target, int budget);
        while (m_cs != target && budget > 0) begin
            cycle();
            budget--;
        end
        if (budget == 0) check("run_to_timeout", m_cs, target);
    endtask
    initial begin
        int pre, n;
        sw_if.clk_100hz = 1'b0;
        {sw_if.key_clr, sw_if.key_lap, sw_if.key_ss} = 3'b000;
        repeat (2) cycle();
        check("rst_disp", sw_if.disp_bcd, 24'h0);
        check("rst_flags", {sw_if.running, sw_if.lap_hold, sw_if.ovf}, 3'b000);
        rst = 1'b1;
        cycle();
        press(3'b001, 1);
        tick_n(100);
        repeat (3) cycle();
        check("t1_disp", sw_if.disp_bcd, 24'h000100);
        check("t1_running", sw_if.running, 1'b1);
        hz_auto = 1'b1;
        run_to(MODC - 1, 60000);
        n = 0;
        while (!m_ovf && n < 100) begin
            cycle();
            n++;
        end
        check("t2_ovf", sw_if.ovf, 1'b1);
        cycle();
        check("t2_ovf_pulse", sw_if.ovf, 1'b0);
        check("t2_wrap_disp", sw_if.disp_bcd[23:8], 16'h0);
        press(3'b001, 1);
        press(3'b100, 1);
        check("t3_cleared", sw_if.disp_bcd, 24'h0);
        press(3'b001, 1);
        run_to(325, 3000);
        press(3'b010, 1);
        check("t3_lap_hold", sw_if.lap_hold, 1'b1);
        run_to(500, 3000);
        check("t3_frozen", sw_if.disp_bcd, 24'h000325);
        press(3'b010, 1);
        repeat (2) cycle();
        check("t3_live", sw_if.lap_hold, 1'b0);
        press(3'b100, 1);
        check("t4_clr_ignored", sw_if.running, 1'b1);
        press(3'b001, 1);
        press(3'b100, 1);
        cycle();
        check("t4_disp", sw_if.disp_bcd, 24'h0);
        check("t4_running", sw_if.running, 1'b0);
        hz_auto = 1'b0;
        sw_if.clk_100hz = 1'b0;
        press(3'b001, 1);
        tick_n(7);
        sw_if.clk_100hz = 1'b1;
        cycle();
        pre = m_cs;
        {sw_if.key_lap, sw_if.key_ss} = 2'b11;
        cycle();
        {sw_if.key_lap, sw_if.key_ss} = 2'b00;
        sw_if.clk_100hz = 1'b0;
        repeat (2) cycle();
        check("t5_stop_tick", sw_if.disp_bcd, bcd(pre + 1));
        check("t5_lap_hold", sw_if.lap_hold, 1'b0);
        check("t5_paused", sw_if.running, 1'b0);
        sw_if.key_ss = 1'b1;
        repeat (1000) cycle();
        check("t5_one_press", sw_if.running, 1'b1);
        sw_if.key_ss = 1'b0;
        cycle();
        hz_auto = 1'b1;
        run_to(1234, 8000);
        rst = 1'b0;
        cycle();
        check("t6_disp", sw_if.disp_bcd, 24'h0);
        check("t6_flags", {sw_if.running, sw_if.lap_hold, sw_if.ovf}, 3'b000);
        rst = 1'b1;
        press(3'b001, 1);
        check("t6_restart", sw_if.running, 1'b1);
        repeat (30) cycle();
        check("t6_from_zero", sw_if.disp_bcd[23:8], 16'h0);
        repeat (4000) begin
            sw_if.key_ss  = $urandom_range(0, 39) == 0;
            sw_if.key_lap = $urandom_range(0, 29) == 0;
            sw_if.key_clr = $urandom_range(0, 29) == 0;
            rst = $urandom_range(0, 999) != 0;
            cycle();
        end
        rst = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
